cache_tag_lookup: RTL and testbench

Parametrised N-way set-associative tag store and lookup unit for the data cache. It holds the tag, valid and dirty bits per way, compares an incoming address tag against every way of the indexed set, and reports hit/miss. On a miss it reports the replacement victim, waits for the cache controller's fill, then installs the new tag. It sits between the CPU-side address split (tag/index) and the cache controller FSM, and replaces the single-way combinational tag comparator.

---
 rtl/cache_tag_lookup.sv | 177 +++++++++++++++++
 tb/tb_cache_tag_lookup.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store with parallel lookup, LRU replacement and fill install.
// One request in flight: IDLE accepts, COMPARE responds, MISS_WAIT holds the victim until fill.
module cache_tag_lookup #(
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned WAYS    = 2,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               resp_valid,
    output logic               hit,
    output logic [WAY_W-1:0]   hit_way,
    output logic [WAY_W-1:0]   victim_way,
    output logic               victim_valid,
    output logic               victim_dirty,
    output logic [TAG_W-1:0]   victim_tag,
    input  logic               fill_valid,
    input  logic               flush
);

    localparam int unsigned SETS = 1 << INDEX_W;

    typedef logic [WAY_W-1:0] way_t;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StMissWait
    } state_e;

    state_e state_q, state_d;

    logic [INDEX_W-1:0] req_index_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic               req_write_q;

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    way_t             age_q   [SETS][WAYS];

    logic hit_found;
    way_t hit_sel;
    logic inv_found;
    way_t inv_sel;
    way_t lru_sel;
    way_t vic_sel;

    logic do_flush;
    logic do_touch;
    logic do_fill;
    way_t touch_way;
    logic show_vic;

    // Descending scan so the lowest-numbered matching/invalid way wins.
    always_comb begin
        hit_found = 1'b0;
        hit_sel   = '0;
        inv_found = 1'b0;
        inv_sel   = '0;
        lru_sel   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[req_index_q][w] && (tag_q[req_index_q][w] == req_tag_q)) begin
                hit_found = 1'b1;
                hit_sel   = way_t'(w);
            end
            if (!valid_q[req_index_q][w]) begin
                inv_found = 1'b1;
                inv_sel   = way_t'(w);
            end
            if (age_q[req_index_q][w] == way_t'(WAYS - 1)) begin
                lru_sel = way_t'(w);
            end
        end
        vic_sel = inv_found ? inv_sel : lru_sel;
    end

    always_comb begin
        state_d   = state_q;
        do_flush  = 1'b0;
        do_touch  = 1'b0;
        do_fill   = 1'b0;
        touch_way = hit_sel;
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else if (req_valid) begin
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (hit_found) begin
                    do_touch = 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d = StMissWait;
                end
            end
            StMissWait: begin
                if (fill_valid) begin
                    do_fill   = 1'b1;
                    touch_way = vic_sel;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StCompare);
    assign hit        = resp_valid && hit_found;
    assign hit_way    = hit ? hit_sel : '0;

    // Victim stays visible through MISS_WAIT; the array cannot change until the fill edge.
    assign show_vic     = ((state_q == StCompare) && !hit_found) || (state_q == StMissWait);
    assign victim_way   = show_vic ? vic_sel : '0;
    assign victim_valid = show_vic && valid_q[req_index_q][vic_sel];
    assign victim_dirty = show_vic && dirty_q[req_index_q][vic_sel];
    assign victim_tag   = show_vic ? tag_q[req_index_q][vic_sel] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            req_index_q <= '0;
            req_tag_q   <= '0;
            req_write_q <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= way_t'(w);
                end
            end
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && req_valid && !flush) begin
                req_index_q <= req_index;
                req_tag_q   <= req_tag;
                req_write_q <= req_write;
            end
            if (do_flush) begin
                for (int s = 0; s < int'(SETS); s++) begin
                    valid_q[s] <= '0;
                    dirty_q[s] <= '0;
                end
            end
            if (do_touch && req_write_q) begin
                dirty_q[req_index_q][hit_sel] <= 1'b1;
            end
            if (do_fill) begin
                tag_q[req_index_q][vic_sel]   <= req_tag_q;
                valid_q[req_index_q][vic_sel] <= 1'b1;
                dirty_q[req_index_q][vic_sel] <= req_write_q;
            end
            // Ages younger than the touched way shift up by one; touched way becomes youngest.
            if (do_touch || do_fill) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (way_t'(w) == touch_way) begin
                        age_q[req_index_q][w] <= '0;
                    end else if (age_q[req_index_q][w] < age_q[req_index_q][touch_way]) begin
                        age_q[req_index_q][w] <= age_q[req_index_q][w] + way_t'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup: default 2-way instance plus a 4-way/8-bit-tag instance.
module tb_cache_tag_lookup;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [2:0] req_index = '0;
    logic [2:0] req_tag = '0;
    logic       fill_valid = 1'b0;
    logic       flush = 1'b0;
    logic       req_ready;
    logic       resp_valid;
    logic       hit;
    logic [0:0] hit_way;
    logic [0:0] victim_way;
    logic       victim_valid;
    logic       victim_dirty;
    logic [2:0] victim_tag;

    logic       req_valid4 = 1'b0;
    logic       req_write4 = 1'b0;
    logic [2:0] req_index4 = '0;
    logic [7:0] req_tag4 = '0;
    logic       fill_valid4 = 1'b0;
    logic       flush4 = 1'b0;
    logic       req_ready4;
    logic       resp_valid4;
    logic       hit4;
    logic [1:0] hit_way4;
    logic [1:0] victim_way4;
    logic       victim_valid4;
    logic       victim_dirty4;
    logic [7:0] victim_tag4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cache_tag_lookup dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_index    (req_index),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .fill_valid   (fill_valid),
        .flush        (flush)
    );

    cache_tag_lookup #(
        .TAG_W   (8),
        .INDEX_W (3),
        .WAYS    (4)
    ) dut4 (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid4),
        .req_ready    (req_ready4),
        .req_write    (req_write4),
        .req_index    (req_index4),
        .req_tag      (req_tag4),
        .resp_valid   (resp_valid4),
        .hit          (hit4),
        .hit_way      (hit_way4),
        .victim_way   (victim_way4),
        .victim_valid (victim_valid4),
        .victim_dirty (victim_dirty4),
        .victim_tag   (victim_tag4),
        .fill_valid   (fill_valid4),
        .flush        (flush4)
    );

    typedef struct {
        logic [2:0] idx;
        logic [2:0] tag;
        logic       wr;
        logic       exp_hit;
        int         exp_way;
        logic       exp_vv;
        logic       exp_vd;
        int         exp_vtag;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs();
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_hit_way", int'(hit_way), 0);
        chk("rst_victim_way", int'(victim_way), 0);
        chk("rst_victim_valid", int'(victim_valid), 0);
        chk("rst_victim_dirty", int'(victim_dirty), 0);
        chk("rst_victim_tag", int'(victim_tag), 0);
        chk("rst_ready4", int'(req_ready4), 1);
        chk("rst_resp_valid4", int'(resp_valid4), 0);
    endtask

    // Present a request in IDLE, check the COMPARE response, optionally fill on a miss.
    task automatic lookup(input logic [2:0] idx, input logic [2:0] tag, input logic wr,
                          input logic exp_hit, input int exp_way, input logic exp_vv,
                          input logic exp_vd, input int exp_vtag, input logic do_fill);
        @(negedge clock);
        chk("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_index = idx;
        req_tag   = tag;
        req_write = wr;
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        chk("resp_valid", int'(resp_valid), 1);
        chk("ready_in_compare", int'(req_ready), 0);
        chk("hit", int'(hit), int'(exp_hit));
        if (exp_hit) begin
            chk("hit_way", int'(hit_way), exp_way);
        end else begin
            chk("victim_way", int'(victim_way), exp_way);
            chk("victim_valid", int'(victim_valid), int'(exp_vv));
            chk("victim_dirty", int'(victim_dirty), int'(exp_vd));
            chk("victim_tag", int'(victim_tag), exp_vtag);
            if (do_fill) begin
                @(negedge clock);
                chk("mw_resp_valid", int'(resp_valid), 0);
                chk("mw_victim_way", int'(victim_way), exp_way);
                chk("mw_victim_tag", int'(victim_tag), exp_vtag);
                fill_valid = 1'b1;
                @(negedge clock);
                fill_valid = 1'b0;
            end
        end
    endtask

    task automatic lookup4(input logic [7:0] tag, input logic exp_hit, input int exp_way,
                           input logic exp_vv, input int exp_vtag);
        @(negedge clock);
        chk("ready4_before_req", int'(req_ready4), 1);
        req_valid4 = 1'b1;
        req_index4 = 3'd0;
        req_tag4   = tag;
        @(negedge clock);
        req_valid4 = 1'b0;
        chk("resp_valid4", int'(resp_valid4), 1);
        chk("hit4", int'(hit4), int'(exp_hit));
        if (exp_hit) begin
            chk("hit_way4", int'(hit_way4), exp_way);
        end else begin
            chk("victim_way4", int'(victim_way4), exp_way);
            chk("victim_valid4", int'(victim_valid4), int'(exp_vv));
            chk("victim_tag4", int'(victim_tag4), exp_vtag);
            @(negedge clock);
            fill_valid4 = 1'b1;
            @(negedge clock);
            fill_valid4 = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        //          idx   tag   wr    hit   way vv    vd    vtag
        vecs[0]  = '{3'd5, 3'd3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
        vecs[1]  = '{3'd5, 3'd3, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0};
        vecs[2]  = '{3'd5, 3'd3, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0};
        vecs[3]  = '{3'd5, 3'd7, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        vecs[4]  = '{3'd5, 3'd2, 1'b0, 1'b0, 0, 1'b1, 1'b1, 3};
        vecs[5]  = '{3'd2, 3'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
        vecs[6]  = '{3'd2, 3'd6, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        vecs[7]  = '{3'd2, 3'd1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0};
        vecs[8]  = '{3'd2, 3'd4, 1'b0, 1'b0, 1, 1'b1, 1'b0, 6};
        vecs[9]  = '{3'd7, 3'd2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
        vecs[10] = '{3'd7, 3'd5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        vecs[11] = '{3'd7, 3'd5, 1'b0, 1'b1, 1, 1'b0, 1'b0, 0};
        vecs[12] = '{3'd7, 3'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 2};
        vecs[13] = '{3'd7, 3'd1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 5};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk_idle_outputs();

        for (int i = 0; i < 14; i++) begin
            lookup(vecs[i].idx, vecs[i].tag, vecs[i].wr, vecs[i].exp_hit, vecs[i].exp_way,
                   vecs[i].exp_vv, vecs[i].exp_vd, vecs[i].exp_vtag, 1'b1);
        end

        // Reset while parked in MISS_WAIT with a fill pending.
        lookup(3'd3, 3'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clock);
        chk("mw_ready", int'(req_ready), 0);
        reset      = 1'b1;
        fill_valid = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        fill_valid = 1'b0;
        chk_idle_outputs();
        lookup(3'd3, 3'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        lookup(3'd5, 3'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Populate every set, then flush with a simultaneous request.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            lookup(3'(i), 3'(i), 1'(i), 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            lookup(3'(i), 3'(i), 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        end
        @(negedge clock);
        chk("flush_ready", int'(req_ready), 1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_index = 3'd1;
        req_tag   = 3'd1;
        @(negedge clock);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_not_accepted", int'(resp_valid), 0);
        chk("flush_ready_after", int'(req_ready), 1);
        fill_valid = 1'b1;
        @(negedge clock);
        fill_valid = 1'b0;
        chk("idle_fill_ready", int'(req_ready), 1);
        chk("idle_fill_resp", int'(resp_valid), 0);
        // Tags survive a flush; only valid/dirty clear.
        for (int i = 0; i < 8; i++) begin
            lookup(3'(i), 3'(i), 1'b0, 1'b0, 0, 1'b0, 1'b0, i, 1'b1);
        end

        // 4-way LRU ordering on set 0.
        do_reset();
        lookup4(8'd10, 1'b0, 0, 1'b0, 0);
        lookup4(8'd11, 1'b0, 1, 1'b0, 0);
        lookup4(8'd12, 1'b0, 2, 1'b0, 0);
        lookup4(8'd13, 1'b0, 3, 1'b0, 0);
        lookup4(8'd10, 1'b1, 0, 1'b0, 0);
        lookup4(8'd11, 1'b1, 1, 1'b0, 0);
        lookup4(8'd12, 1'b1, 2, 1'b0, 0);
        lookup4(8'd13, 1'b1, 3, 1'b0, 0);
        lookup4(8'd11, 1'b1, 1, 1'b0, 0);
        lookup4(8'd20, 1'b0, 0, 1'b1, 10);
        lookup4(8'd20, 1'b1, 0, 1'b0, 0);
        lookup4(8'd21, 1'b0, 2, 1'b1, 12);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
